// File: rtl/retire_trace_buffer_pkg.sv
// trace_pkg: shared definitions for the retirement trace recorder.
// Holds the record class encodings, the fixed-width payload carried per
// record, and the classification priority used to pick a record class.
package trace_pkg;

   typedef enum logic [2:0] {
      KIND_NONE = 3'd0,
      KIND_STU  = 3'd1,
      KIND_LD   = 3'd2,
      KIND_REG  = 3'd3,
      KIND_HALT = 3'd4,
      KIND_ST   = 3'd5,
      KIND_NOP  = 3'd6
   } kind_e;

   localparam int PC_W   = 16;
   localparam int REG_W  = 3;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   // Counter-independent part of a record; inum/cycle are prepended by the
   // top level because their width is a parameter of the instance.
   typedef struct packed {
      kind_e              kind;
      logic [PC_W-1:0]    pc;
      logic [REG_W-1:0]   wreg;
      logic [DATA_W-1:0]  value;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  mdata;
   } payload_t;

   localparam int PAYLOAD_W = $bits(payload_t);

   // First match wins: a register write dominates, then halt, then a plain store.
   function automatic kind_e classify(input logic regwrite,
                                      input logic memread,
                                      input logic memwrite,
                                      input logic halt);
      kind_e k;
      if (regwrite && memwrite)     k = KIND_STU;
      else if (regwrite && memread) k = KIND_LD;
      else if (regwrite)            k = KIND_REG;
      else if (halt)                k = KIND_HALT;
      else if (memwrite)            k = KIND_ST;
      else                          k = KIND_NOP;
      return k;
   endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// retire_trace_buffer_if: retirement bus into the recorder plus the drain
// port out of it.
//   ret_*  : retiring-instruction signals (valid, pc, regfile write, memory op, halt)
//   rd_*   : head-of-FIFO record and its valid/ready handshake
// master = retirement source / drain consumer, slave = recorder.
interface retire_trace_buffer_if #(parameter int CNT_W = 32);
   logic             ret_valid;
   logic [15:0]      ret_pc;
   logic             ret_regwrite;
   logic [2:0]       ret_wreg;
   logic [15:0]      ret_wdata;
   logic             ret_memread;
   logic             ret_memwrite;
   logic [15:0]      ret_maddr;
   logic [15:0]      ret_mdata;
   logic             ret_halt;

   logic             rd_ready;
   logic             rd_valid;
   logic [2:0]       rd_kind;
   logic [CNT_W-1:0] rd_inum;
   logic [CNT_W-1:0] rd_cycle;
   logic [15:0]      rd_pc;
   logic [2:0]       rd_reg;
   logic [15:0]      rd_value;
   logic [15:0]      rd_addr;
   logic [15:0]      rd_mdata;

   modport master (
      output ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
             ret_memread, ret_memwrite, ret_maddr, ret_mdata, ret_halt,
             rd_ready,
      input  rd_valid, rd_kind, rd_inum, rd_cycle, rd_pc, rd_reg,
             rd_value, rd_addr, rd_mdata
   );

   modport slave (
      input  ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
             ret_memread, ret_memwrite, ret_maddr, ret_mdata, ret_halt,
             rd_ready,
      output rd_valid, rd_kind, rd_inum, rd_cycle, rd_pc, rd_reg,
             rd_value, rd_addr, rd_mdata
   );
endinterface

// File: rtl/retire_trace_buffer_fifo.sv
// trace_fifo: generic DEPTH x WIDTH synchronous FIFO.
//   clk, rst      : clock, synchronous active-low reset (pointers only)
//   push/push_data: write request; taken when not full, or when full with a pop
//   pop           : read request; ignored while empty
//   full/empty    : status from the wrap-bit pointer compare
//   count         : exact occupancy, 0..DEPTH
//   head          : oldest entry, combinational
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                (wr_ptr_q[AW] != rd_ptr_q[AW]);
      count   = wr_ptr_q - rd_ptr_q;
      head    = mem_q[rd_ptr_q[AW-1:0]];
      pop_ok  = pop && !empty;
      // When full, the slot being written is the one being freed this cycle;
      // the head read above still sees the old contents.
      push_ok = push && (!full || pop_ok);

      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);

      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: commit-trace recorder behind the retirement point.
//   clk, rst    : clock, synchronous active-low reset
//   bus (slave) : retirement inputs and the rd_* drain port
//   inst_count  : records accepted (including dropped ones)
//   cycle_count : free-running cycles since reset release
//   halted      : sticky, a HALT record was accepted
//   done        : halted and nothing left to drain
//   overflow    : sticky, a record was dropped on a full FIFO
//   occupancy   : records currently buffered
module retire_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   retire_trace_buffer_if.slave    bus,
   output logic [CNT_W-1:0]        inst_count,
   output logic [CNT_W-1:0]        cycle_count,
   output logic                    halted,
   output logic                    done,
   output logic                    overflow,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int REC_W = PAYLOAD_W + 2 * CNT_W;

   logic [CNT_W-1:0] inst_count_q, inst_count_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic             halted_q, halted_d;
   logic             overflow_q, overflow_d;

   logic             accept;
   payload_t         new_pl;
   logic [REC_W-1:0] new_rec;

   logic             fifo_full;
   logic             fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [REC_W-1:0] fifo_head;
   payload_t         head_pl;

   always_comb begin
      accept = bus.ret_valid && !halted_q;

      new_pl.kind  = classify(bus.ret_regwrite, bus.ret_memread,
                              bus.ret_memwrite, bus.ret_halt);
      new_pl.pc    = bus.ret_pc;
      new_pl.wreg  = bus.ret_wreg;
      new_pl.value = bus.ret_wdata;
      new_pl.addr  = bus.ret_maddr;
      new_pl.mdata = bus.ret_mdata;
      new_rec      = {inst_count_q, cycle_count_q, new_pl};

      cycle_count_d = cycle_count_q + CNT_W'(1);
      inst_count_d  = inst_count_q + CNT_W'(accept);
      halted_d      = halted_q || (accept && new_pl.kind == KIND_HALT);
      // A full FIFO is never empty, so rd_ready alone means a pop frees a slot.
      overflow_d    = overflow_q || (accept && fifo_full && !bus.rd_ready);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_count_q  <= '0;
         cycle_count_q <= '0;
         halted_q      <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         inst_count_q  <= inst_count_d;
         cycle_count_q <= cycle_count_d;
         halted_q      <= halted_d;
         overflow_q    <= overflow_d;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (new_rec),
      .pop       (bus.rd_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // Drain port reads as all-zero (kind NONE) whenever nothing is buffered,
   // so unwritten storage never leaks out after reset.
   always_comb begin
      head_pl       = fifo_empty ? '0 : payload_t'(fifo_head[PAYLOAD_W-1:0]);
      bus.rd_valid  = !fifo_empty;
      bus.rd_kind   = head_pl.kind;
      bus.rd_pc     = head_pl.pc;
      bus.rd_reg    = head_pl.wreg;
      bus.rd_value  = head_pl.value;
      bus.rd_addr   = head_pl.addr;
      bus.rd_mdata  = head_pl.mdata;
      bus.rd_inum   = fifo_empty ? '0 : fifo_head[REC_W-1 -: CNT_W];
      bus.rd_cycle  = fifo_empty ? '0 : fifo_head[PAYLOAD_W+CNT_W-1 -: CNT_W];
   end

   assign inst_count  = inst_count_q;
   assign cycle_count = cycle_count_q;
   assign halted      = halted_q;
   assign overflow    = overflow_q;
   assign occupancy   = fifo_count;
   assign done        = halted_q && fifo_empty;

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
Synthesizable commit-trace recorder sitting directly downstream of the processor's retirement point (writeback/memory commit signals). Each cycle it classifies the retiring instruction into a trace record and stamps it with instruction and cycle numbers. It buffers records in a FIFO for a drain port (UART/debug reader) and tracks halt for end-of-run detection. It is the hardware equivalent of the simulation trace monitor and uses the same record classes.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >=2
CNT_W, 32, width of cycle and instruction counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
ret_valid  in  1  an instruction retires this cycle
ret_pc  in  16  PC of retiring instruction
ret_regwrite  in  1  register file write
ret_wreg  in  3  destination register
ret_wdata  in  16  register write data
ret_memread  in  1  memory read
ret_memwrite  in  1  memory write
ret_maddr  in  16  memory address
ret_mdata  in  16  memory write data
ret_halt  in  1  HALT retiring
rd_ready  in  1  consumer pops head record
rd_valid  out  1  FIFO non-empty
rd_kind  out  3  head record class
rd_inum  out  CNT_W  head instruction number
rd_cycle  out  CNT_W  head cycle stamp
rd_pc  out  16  head PC
rd_reg  out  3  head destination register
rd_value  out  16  head register value
rd_addr  out  16  head memory address
rd_mdata  out  16  head memory data
inst_count  out  CNT_W  records accepted so far
cycle_count  out  CNT_W  cycles since reset release
halted  out  1  sticky, HALT accepted
done  out  1  halted and FIFO empty
overflow  out  1  sticky, a record was dropped
occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst==0 at posedge): all outputs 0, FIFO emptied, counters 0. Reset mid-operation discards buffered records with no partial pop.
- cycle_count: +1 every cycle out of reset; wraps at 2^CNT_W; never stops, even when halted.
- Classification, first match wins: regwrite&memwrite -> STU(1); regwrite&memread -> LD(2); regwrite -> REG(3); halt -> HALT(4); memwrite -> ST(5); else NOP(6). Code 0 is reserved (empty).
- Accept condition: ret_valid & !halted. Ignored cycles do not change inst_count.
- Accepted record: inum = inst_count before increment, cycle = current cycle_count, all fields copied raw (unused fields are stored but meaningless). inst_count +1 on every accepted record, including dropped ones.
- Push succeeds if not full, or if full and a pop occurs in the same cycle. Otherwise the record is dropped and overflow is set (sticky until reset).
- Latency: an accepted record appears at rd_* on the next cycle. rd_* is combinational from the head entry and holds stable while rd_valid & !rd_ready.
- Pop: rd_valid & rd_ready. rd_ready while empty has no effect.
- Simultaneous push and pop on an empty FIFO: record still appears next cycle; no bypass.
- Pointers: log2(DEPTH) bits plus a wrap bit. Full = same index with wrap bits differing.
- HALT: accepting a HALT record sets halted the next cycle; all later ret_valid is ignored until reset. done = halted & (occupancy==0).
- occupancy is exact under every push/pop combination.

Decomposition:
- Package trace_pkg: kind encodings (KIND_NONE..KIND_NOP), record struct/field widths, classification priority function.
- One sub-module, trace_fifo: generic DEPTH x record-width synchronous FIFO exposing full/empty/count.
- Top level holds the counters, classifier, halt/overflow flags and drain glue.

Test Plan:
- Reset then 5 idle cycles -> cycle_count=5, inst_count=0, rd_valid=0, done=0.
- ret_valid with regwrite, wreg=3, wdata=0x1234, pc=0x0002 -> next cycle rd_valid=1, kind=REG, inum=0, rd_value=0x1234, rd_pc=0x0002.
- Same cycle regwrite+memwrite, addr=0x0010, mdata=0xBEEF -> kind=STU; regwrite+memread -> LD; memwrite only -> ST; none -> NOP; inum increments 1,2,3,4.
- 17 retirements with rd_ready=0, DEPTH=16 -> occupancy=16, overflow=1, inst_count=17. Then full + push + pop in the same cycle -> push accepted, occupancy stays 16.
- HALT at pc=0x0020, then 3 further ret_valid -> halted=1, inst_count unchanged after HALT. Drain all entries -> done=1 on the cycle occupancy reaches 0.
- rst=0 pulsed with 8 entries buffered -> next cycle occupancy=0, halted=0, overflow=0, cycle_count=0.
